unlock_sender: RTL and testbench

//   Transmit side of the ASCII unlock interface: on a start request, drives a stored code

---
 rtl/unlock_pkg.sv | 17 +
 rtl/unlock_sender_if.sv | 29 ++
 rtl/unlock_timer.sv | 27 ++
 rtl/unlock_sender.sv | 131 +++++++++++++
 tb/tb_unlock_sender.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/unlock_pkg.sv
// Shared state encoding and ASCII constants for the unlock sender.
package unlock_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND   = 2'd1,
      WAIT   = 2'd2,
      REPORT = 2'd3
   } state_t;

   localparam logic [7:0] ASCII_NUL = 8'h00;
   localparam logic [7:0] ASCII_A   = 8'h41;
   localparam logic [7:0] ASCII_B   = 8'h42;
   localparam logic [7:0] ASCII_C   = 8'h43;
   localparam logic [7:0] ASCII_D   = 8'h44;

endpackage

// File: rtl/unlock_sender_if.sv
// Control/detector-facing signal bundle of the unlock sender.
interface unlock_sender_if;

   logic       start;
   logic       unlock_in;
   logic [7:0] ascii_out;
   logic       busy;
   logic       done;
   logic       fail;

   modport master (
      output start,
      output unlock_in,
      input  ascii_out,
      input  busy,
      input  done,
      input  fail
   );

   modport slave (
      input  start,
      input  unlock_in,
      output ascii_out,
      output busy,
      output done,
      output fail
   );

endinterface

// File: rtl/unlock_timer.sv
// Saturating 8-bit wait counter; expired flags cnt==TIMEOUT-1, combinational off the register.
// No backpressure: clr has priority over en.
module unlock_timer #(
   parameter int TIMEOUT = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

   logic [7:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt <= 8'd0;
      end else if (en && (cnt != 8'hFF)) begin
         cnt <= cnt + 8'd1;
      end
   end

   assign expired = (cnt == LAST_CNT);

endmodule

// File: rtl/unlock_sender.sv
// Sends CODE one char per cycle from the start edge, then waits TIMEOUT cycles for unlock_in.
// No backpressure: start is dropped unless IDLE. Optional resend on timeout: UNLOCK_RETRY_EN.
module unlock_sender
   import unlock_pkg::*;
#(
   parameter int                    CODE_LEN  = 7,
   parameter logic [8*CODE_LEN-1:0] CODE      = "ABCABCD",
   parameter int                    TIMEOUT   = 8,
   parameter int                    MAX_RETRY = 2
) (
   input  logic           clk,
   input  logic           reset,
   unlock_sender_if.slave ul
);

   localparam int                IDX_W      = $clog2(CODE_LEN + 1);
   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(CODE_LEN);
   localparam logic [7:0]        FIRST_CHAR = CODE[8*CODE_LEN-1 -: 8];

   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic [7:0]       ascii_nxt;
   logic             done_nxt, fail_nxt;
   logic             expired;
   logic [8*CODE_LEN-1:0] code_sh;
   logic [7:0]       cur_char;

`ifdef UNLOCK_RETRY_EN
   localparam int               RETRY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
   logic [RETRY_W-1:0] retry_cnt, retry_nxt;
`else
   logic unused_max_retry;
   assign unused_max_retry = (MAX_RETRY != 0);
`endif

   assign code_sh  = CODE << {idx, 3'b000};
   assign cur_char = code_sh[8*CODE_LEN-1 -: 8];

   unlock_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clr     (state != WAIT),
      .en      (state == WAIT),
      .expired (expired)
   );

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      ascii_nxt = ASCII_NUL;
      done_nxt  = 1'b0;
      fail_nxt  = 1'b0;
`ifdef UNLOCK_RETRY_EN
      retry_nxt = retry_cnt;
`endif
      case (state)
         IDLE: begin
`ifdef UNLOCK_RETRY_EN
            retry_nxt = '0;
`endif
            if (ul.start) begin
               state_nxt = SEND;
               ascii_nxt = FIRST_CHAR;
               idx_nxt   = IDX_W'(1);
            end
         end
         SEND: begin
            if (idx < LAST_IDX) begin
               ascii_nxt = cur_char;
               idx_nxt   = idx + IDX_W'(1);
            end else begin
               state_nxt = WAIT;
               idx_nxt   = '0;
            end
         end
         WAIT: begin
            // unlock wins over a timeout landing in the same cycle
            if (ul.unlock_in) begin
               state_nxt = REPORT;
               done_nxt  = 1'b1;
            end else if (expired) begin
`ifdef UNLOCK_RETRY_EN
               if (retry_cnt < RETRY_MAX) begin
                  retry_nxt = retry_cnt + RETRY_W'(1);
                  state_nxt = SEND;
                  idx_nxt   = '0;
               end else begin
                  state_nxt = REPORT;
                  fail_nxt  = 1'b1;
               end
`else
               state_nxt = REPORT;
               fail_nxt  = 1'b1;
`endif
            end
         end
         REPORT: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         idx          <= '0;
         ul.ascii_out <= ASCII_NUL;
         ul.busy      <= 1'b0;
         ul.done      <= 1'b0;
         ul.fail      <= 1'b0;
`ifdef UNLOCK_RETRY_EN
         retry_cnt    <= '0;
`endif
      end else begin
         state        <= state_nxt;
         idx          <= idx_nxt;
         ul.ascii_out <= ascii_nxt;
         ul.busy      <= (state_nxt == SEND) || (state_nxt == WAIT);
         ul.done      <= done_nxt;
         ul.fail      <= fail_nxt;
`ifdef UNLOCK_RETRY_EN
         retry_cnt    <= retry_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_unlock_sender.sv
// Directed bench for unlock_sender: outputs sampled 1 time unit after each rising edge.
module tb_unlock_sender;
   import unlock_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;
   int   done_cnt = 0;
   int   fail_cnt = 0;
   int   d_cnt = 0;
   int   base_done, base_fail, base_d;

   logic [7:0] exp_code [7] = '{ASCII_A, ASCII_B, ASCII_C, ASCII_A, ASCII_B, ASCII_C, ASCII_D};

   unlock_sender_if ul ();

   unlock_sender dut (
      .clk   (clk),
      .reset (reset),
      .ul    (ul)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ul.done) done_cnt++;
      if (ul.fail) fail_cnt++;
      if (ul.ascii_out == ASCII_D) d_cnt++;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // first=1: pulse start from IDLE; first=0: retry pass beginning with the idle slot.
   // noise=1 holds start and unlock_in high for the whole character phase.
   // Returns positioned in the first WAIT cycle.
   task automatic send_pass(input bit first, input bit noise);
      if (first) begin
         ul.start = 1'b1;
         tick();
         ul.start = 1'b0;
      end else begin
         chk("retry_gap_ascii", ul.ascii_out, 8'h00);
         chk("retry_gap_busy", ul.busy, 1);
         tick();
      end
      for (int i = 0; i < 7; i++) begin
         if (noise) begin
            ul.start     = 1'b1;
            ul.unlock_in = 1'b1;
         end
         chk("char", ul.ascii_out, exp_code[i]);
         chk("send_busy", ul.busy, 1);
         chk("send_done", ul.done, 0);
         tick();
      end
      ul.start     = 1'b0;
      ul.unlock_in = 1'b0;
      chk("wait0_ascii", ul.ascii_out, 8'h00);
   endtask

   task automatic wait_cycles(input int n);
      for (int j = 0; j < n; j++) begin
         chk("wait_busy", ul.busy, 1);
         chk("wait_ascii", ul.ascii_out, 8'h00);
         chk("wait_pulses", {ul.done, ul.fail}, 2'b00);
         tick();
      end
   endtask

   initial begin
      reset        = 1'b1;
      ul.start     = 1'b0;
      ul.unlock_in = 1'b0;

      // 1. reset
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("rst_ascii", ul.ascii_out, 8'h00);
         chk("rst_busy", ul.busy, 0);
         chk("rst_pulses", {ul.done, ul.fail}, 2'b00);
      end
      reset = 1'b0;
      tick();

      // 2. unlock in second WAIT cycle: busy for 9 cycles, one done
      base_done = done_cnt;
      send_pass(1'b1, 1'b0);
      wait_cycles(1);
      ul.unlock_in = 1'b1;
      chk("t2_busy_w1", ul.busy, 1);
      tick();
      ul.unlock_in = 1'b0;
      chk("t2_done", ul.done, 1);
      chk("t2_fail", ul.fail, 0);
      chk("t2_busy_rep", ul.busy, 0);
      tick();
      chk("t2_done_clr", ul.done, 0);
      chk("t2_done_once", done_cnt - base_done, 1);

`ifndef UNLOCK_RETRY_EN
      // 3. timeout without retry
      base_done = done_cnt;
      send_pass(1'b1, 1'b0);
      wait_cycles(8);
      chk("t3_fail", ul.fail, 1);
      chk("t3_busy", ul.busy, 0);
      tick();
      chk("t3_fail_clr", ul.fail, 0);
      chk("t3_no_done", done_cnt - base_done, 0);
`else
      // 4a. three attempts then fail
      base_d = d_cnt;
      base_fail = fail_cnt;
      send_pass(1'b1, 1'b0);
      wait_cycles(8);
      send_pass(1'b0, 1'b0);
      wait_cycles(8);
      send_pass(1'b0, 1'b0);
      wait_cycles(8);
      chk("t4_fail", ul.fail, 1);
      tick();
      chk("t4_sends", d_cnt - base_d, 3);
      chk("t4_fail_once", fail_cnt - base_fail, 1);
      // 4b. unlock in the second WAIT: no third send
      base_d = d_cnt;
      send_pass(1'b1, 1'b0);
      wait_cycles(8);
      send_pass(1'b0, 1'b0);
      wait_cycles(2);
      ul.unlock_in = 1'b1;
      tick();
      ul.unlock_in = 1'b0;
      chk("t4b_done", ul.done, 1);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t4b_idle_ascii", ul.ascii_out, 8'h00);
         chk("t4b_idle_busy", ul.busy, 0);
      end
      chk("t4b_sends", d_cnt - base_d, 2);
`endif

      // 5. start/unlock noise during SEND, start during REPORT
      base_done = done_cnt;
      send_pass(1'b1, 1'b1);
      chk("t5_no_done_send", done_cnt - base_done, 0);
      wait_cycles(1);
      ul.unlock_in = 1'b1;
      tick();
      ul.unlock_in = 1'b0;
      chk("t5_done", ul.done, 1);
      ul.start = 1'b1;
      tick();
      ul.start = 1'b0;
      chk("t5_rep_start_busy", ul.busy, 0);
      chk("t5_rep_start_ascii", ul.ascii_out, 8'h00);
      tick();
      chk("t5_not_queued", ul.busy, 0);
      chk("t5_done_once", done_cnt - base_done, 1);

      // 6. reset at the 4th character
      base_done = done_cnt;
      base_fail = fail_cnt;
      ul.start = 1'b1;
      tick();
      ul.start = 1'b0;
      tick();
      tick();
      tick();
      chk("t6_char4", ul.ascii_out, ASCII_A);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_ascii", ul.ascii_out, 8'h00);
      chk("t6_busy", ul.busy, 0);
      for (int i = 0; i < 12; i++) tick();
      chk("t6_no_pulse", (done_cnt - base_done) + (fail_cnt - base_fail), 0);
      send_pass(1'b1, 1'b0);
      wait_cycles(1);
      ul.unlock_in = 1'b1;
      tick();
      ul.unlock_in = 1'b0;
      chk("t6_done", ul.done, 1);
      tick();

      // 7. unlock in the exact timeout cycle
      send_pass(1'b1, 1'b0);
      wait_cycles(7);
      ul.unlock_in = 1'b1;
      tick();
      ul.unlock_in = 1'b0;
      chk("t7_done", ul.done, 1);
      chk("t7_fail", ul.fail, 0);
      tick();
      chk("t7_idle", ul.busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
